// File: rtl/debounce_pkg.sv
// -----------------------------------------------------------------------------
// debounce_pkg
// Shared types and constants for the multi-channel debounce block.
//   db_state_t  : per-channel qualification state
//   GLITCH_W    : width of each per-channel glitch counter
//   GLITCH_MAX  : saturation value of a glitch counter
// -----------------------------------------------------------------------------
package debounce_pkg;

    typedef enum logic {
        DB_IDLE = 1'b0,
        DB_QUAL = 1'b1
    } db_state_t;

    localparam int                  GLITCH_W   = 8;
    localparam logic [GLITCH_W-1:0] GLITCH_MAX = 8'hFF;

endpackage

// File: rtl/debounce_ch.sv
// -----------------------------------------------------------------------------
// debounce_ch
// One debounce channel: 2-flop synchroniser, IDLE/QUAL state machine,
// tick-driven hold counter and, optionally, a saturating glitch counter.
//
// Optional feature macro: DEBOUNCE_GLITCH_CNT_EN
//   When defined, the channel counts aborted qualifications and exposes
//   iGlitch_clr / oGlitch_cnt.
//
// Ports
//   iCLK, iRst_n     clock, asynchronous active-low reset
//   iTick            timebase strobe, one iCLK cycle wide
//   iAssert_time     ticks the input must hold 1 before oOut rises
//   iDeassert_time   ticks the input must hold 0 before oOut falls
//   iIn              raw asynchronous input
//   oOut             debounced level
//   oChg             one-cycle pulse in the cycle a new oOut first appears
//   oChg_next        combinational value oChg will take at the next edge
//   iGlitch_clr      synchronous clear of the glitch counter (macro only)
//   oGlitch_cnt      saturating abort counter (macro only)
// -----------------------------------------------------------------------------
module debounce_ch
    import debounce_pkg::*;
#(
    parameter int   CNT_W   = 16,
    parameter logic RST_VAL = 1'b0
) (
    input  logic             iCLK,
    input  logic             iRst_n,
    input  logic             iTick,
    input  logic [CNT_W-1:0] iAssert_time,
    input  logic [CNT_W-1:0] iDeassert_time,
    input  logic             iIn,
    output logic             oOut,
    output logic             oChg,
    output logic             oChg_next
`ifdef DEBOUNCE_GLITCH_CNT_EN
    ,
    input  logic                iGlitch_clr,
    output logic [GLITCH_W-1:0] oGlitch_cnt
`endif
);

    localparam logic [CNT_W:0] CNT_ONE = {{CNT_W{1'b0}}, 1'b1};

    logic             sync_a;
    logic             sync_b;
    db_state_t        state;
    db_state_t        state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] thr;
    logic [CNT_W:0]   cnt_plus;
    logic             reached;
    logic             out_nxt;
    logic             chg_nxt;

    // Synchroniser stages reset to the channel's reset level so that an input
    // already sitting at that level produces no activity after reset.
    always_ff @(posedge iCLK or negedge iRst_n) begin
        if (!iRst_n) begin
            sync_a <= RST_VAL;
            sync_b <= RST_VAL;
        end else begin
            sync_a <= iIn;
            sync_b <= sync_a;
        end
    end

    assign thr = oOut ? iDeassert_time : iAssert_time;

    // Compare count+1 >= thr in one extra bit rather than count >= thr-1:
    // it cannot underflow when the threshold is lowered to zero while a
    // qualification is already running, and it still terminates when the
    // threshold drops below the current count.
    assign cnt_plus = {1'b0, cnt} + CNT_ONE;
    assign reached  = (cnt_plus >= {1'b0, thr});

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        out_nxt   = oOut;
        chg_nxt   = 1'b0;
        case (state)
            DB_IDLE: begin
                cnt_nxt = '0;
                if (sync_b != oOut) begin
                    if (thr == '0) begin
                        out_nxt = ~oOut;
                        chg_nxt = 1'b1;
                    end else begin
                        // A tick in this entry cycle is deliberately not counted.
                        state_nxt = DB_QUAL;
                    end
                end
            end
            DB_QUAL: begin
                if (sync_b == oOut) begin
                    // Abort has priority over a coincident tick.
                    state_nxt = DB_IDLE;
                    cnt_nxt   = '0;
                end else if (iTick) begin
                    if (reached) begin
                        out_nxt   = ~oOut;
                        chg_nxt   = 1'b1;
                        state_nxt = DB_IDLE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt_plus[CNT_W-1:0];
                    end
                end
            end
            default: begin
                state_nxt = DB_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge iCLK or negedge iRst_n) begin
        if (!iRst_n) begin
            state <= DB_IDLE;
            cnt   <= '0;
            oOut  <= RST_VAL;
            oChg  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            oOut  <= out_nxt;
            oChg  <= chg_nxt;
        end
    end

    assign oChg_next = chg_nxt;

`ifdef DEBOUNCE_GLITCH_CNT_EN
    logic                abort;
    logic [GLITCH_W-1:0] glitch;

    assign abort = (state == DB_QUAL) && (sync_b == oOut);

    // Clear beats a same-cycle increment; the count sticks at GLITCH_MAX.
    always_ff @(posedge iCLK or negedge iRst_n) begin
        if (!iRst_n) begin
            glitch <= '0;
        end else if (iGlitch_clr) begin
            glitch <= '0;
        end else if (abort && (glitch != GLITCH_MAX)) begin
            glitch <= glitch + GLITCH_W'(1);
        end
    end

    assign oGlitch_cnt = glitch;
`endif

endmodule

// File: rtl/debounce_array.sv
// -----------------------------------------------------------------------------
// debounce_array
// Multi-channel debounce sharing one tick timebase and one pair of
// assert/de-assert hold times. Each channel is an independent debounce_ch.
//
// Optional feature macro: DEBOUNCE_GLITCH_CNT_EN
//   When defined, per-channel 8-bit glitch counters are kept and exposed on
//   oGlitch_cnt (channel n at [8n+7:8n]), cleared by iGlitch_clr.
//
// Parameters
//   CH       number of channels (1..32)
//   CNT_W    width of hold-time counters and threshold inputs
//   RST_VAL  per-channel debounced level loaded at reset
//
// Ports
//   iCLK, iRst_n     clock, asynchronous active-low reset
//   iTick            timebase strobe from a shared prescaler
//   iAssert_time     ticks an input must hold 1 before its output rises
//   iDeassert_time   ticks an input must hold 0 before its output falls
//   iIn              raw asynchronous inputs
//   oOut             debounced levels
//   oChg             per-channel one-cycle toggle pulse
//   oAny_chg         registered OR of the toggle pulses, aligned with oChg
//   iGlitch_clr      synchronous clear of all glitch counters (macro only)
//   oGlitch_cnt      flattened glitch counters (macro only)
// -----------------------------------------------------------------------------
module debounce_array
    import debounce_pkg::*;
#(
    parameter int            CH      = 8,
    parameter int            CNT_W   = 16,
    parameter logic [CH-1:0] RST_VAL = {CH{1'b0}}
) (
    input  logic             iCLK,
    input  logic             iRst_n,
    input  logic             iTick,
    input  logic [CNT_W-1:0] iAssert_time,
    input  logic [CNT_W-1:0] iDeassert_time,
    input  logic [CH-1:0]    iIn,
    output logic [CH-1:0]    oOut,
    output logic [CH-1:0]    oChg,
    output logic             oAny_chg
`ifdef DEBOUNCE_GLITCH_CNT_EN
    ,
    input  logic                   iGlitch_clr,
    output logic [GLITCH_W*CH-1:0] oGlitch_cnt
`endif
);

    logic [CH-1:0] chg_next;
    logic          any_q;

    for (genvar n = 0; n < CH; n++) begin : g_ch
        debounce_ch #(
            .CNT_W   (CNT_W),
            .RST_VAL (RST_VAL[n])
        ) u_ch (
            .iCLK           (iCLK),
            .iRst_n         (iRst_n),
            .iTick          (iTick),
            .iAssert_time   (iAssert_time),
            .iDeassert_time (iDeassert_time),
            .iIn            (iIn[n]),
            .oOut           (oOut[n]),
            .oChg           (oChg[n]),
            .oChg_next      (chg_next[n])
`ifdef DEBOUNCE_GLITCH_CNT_EN
            ,
            .iGlitch_clr    (iGlitch_clr),
            .oGlitch_cnt    (oGlitch_cnt[GLITCH_W*n +: GLITCH_W])
`endif
        );
    end

    // Registering the OR of the next-cycle pulses keeps oAny_chg a clean flop
    // output while landing on the same cycle as the individual oChg bits.
    always_ff @(posedge iCLK or negedge iRst_n) begin
        if (!iRst_n) begin
            any_q <= 1'b0;
        end else begin
            any_q <= |chg_next;
        end
    end

    assign oAny_chg = any_q;

endmodule

// File: tb/tb_debounce_array.sv
// -----------------------------------------------------------------------------
// tb_debounce_array
// Self-checking bench for debounce_array with CH=4, RST_VAL=4'b1000 and a
// tick every 4 cycles. Each stimulus pushes the edge number and channel mask
// of the toggle it should cause; a negedge monitor pops and compares, and
// checks oOut/oChg/oAny_chg on every cycle in between.
// Glitch-counter checks are compiled only with DEBOUNCE_GLITCH_CNT_EN.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_debounce_array;

    localparam int             CH      = 4;
    localparam int             CNT_W   = 16;
    localparam logic [CH-1:0]  RST_VAL = 4'b1000;

    logic             iCLK = 1'b0;
    logic             iRst_n;
    logic             iTick = 1'b0;
    logic [CNT_W-1:0] iAssert_time;
    logic [CNT_W-1:0] iDeassert_time;
    logic [CH-1:0]    iIn;
    logic [CH-1:0]    oOut;
    logic [CH-1:0]    oChg;
    logic             oAny_chg;
`ifdef DEBOUNCE_GLITCH_CNT_EN
    logic             iGlitch_clr;
    logic [8*CH-1:0]  oGlitch_cnt;
`endif

    debounce_array #(
        .CH      (CH),
        .CNT_W   (CNT_W),
        .RST_VAL (RST_VAL)
    ) dut (
        .iCLK           (iCLK),
        .iRst_n         (iRst_n),
        .iTick          (iTick),
        .iAssert_time   (iAssert_time),
        .iDeassert_time (iDeassert_time),
        .iIn            (iIn),
        .oOut           (oOut),
        .oChg           (oChg),
        .oAny_chg       (oAny_chg)
`ifdef DEBOUNCE_GLITCH_CNT_EN
        ,
        .iGlitch_clr    (iGlitch_clr),
        .oGlitch_cnt    (oGlitch_cnt)
`endif
    );

    always #5 iCLK = ~iCLK;

    typedef struct {
        int            edge_no;
        logic [CH-1:0] mask;
    } exp_t;

    exp_t          sb[$];
    int            cyc = 0;
    int            tests = 0;
    int            fails = 0;
    logic          tick_en = 1'b1;
    logic          mon_en = 1'b0;
    logic [CH-1:0] exp_level = RST_VAL;
    int            entry;
    int            tgt;

    // cyc counts posedges; at a negedge it names the edge just taken.
    always @(posedge iCLK) cyc <= cyc + 1;

    // Tick is sampled on every edge whose number is a multiple of 4.
    always @(negedge iCLK) iTick = tick_en && (((cyc + 1) % 4) == 0);

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    // First tick edge strictly after the QUAL entry edge, then every 4.
    function automatic int nthTick(input int entry_edge, input int n);
        int first;
        first = ((entry_edge / 4) + 1) * 4;
        return first + 4 * (n - 1);
    endfunction

    // Called at a negedge; returns the edge on which the FSM enters QUAL
    // (which is also the toggle edge when the threshold is zero).
    task automatic applyStimulus(input logic [CH-1:0] val, output int entry_edge);
        iIn        = val;
        entry_edge = cyc + 3;
    endtask

    task automatic expectToggle(input int edge_no, input logic [CH-1:0] mask);
        exp_t e;
        e.edge_no = edge_no;
        e.mask    = mask;
        sb.push_back(e);
    endtask

    task automatic waitDrain(input int budget);
        int n;
        n = 0;
        while (sb.size() > 0 && n < budget) begin
            @(negedge iCLK);
            n++;
        end
        if (sb.size() > 0) begin
            checkOutput("drain_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
        repeat (2) @(negedge iCLK);
    endtask

    task automatic waitEdge(input int edge_no);
        while (cyc < edge_no) @(negedge iCLK);
    endtask

    always @(negedge iCLK) begin : monitor
        exp_t          e;
        logic [CH-1:0] exp_chg;
        if (mon_en) begin
            exp_chg = '0;
            if (sb.size() > 0 && sb[0].edge_no < cyc) begin
                checkOutput("toggle_late", 32'(cyc), 32'(sb[0].edge_no));
                e = sb.pop_front();
                exp_level = exp_level ^ e.mask;
            end
            if (sb.size() > 0 && sb[0].edge_no == cyc) begin
                e = sb.pop_front();
                exp_chg   = e.mask;
                exp_level = exp_level ^ e.mask;
            end
            checkOutput("chg", 32'(oChg), 32'(exp_chg));
            checkOutput("any_chg", 32'(oAny_chg), 32'(exp_chg != '0));
            checkOutput("level", 32'(oOut), 32'(exp_level));
        end
    end

    initial begin
        iRst_n         = 1'b0;
        iIn            = RST_VAL;
        iAssert_time   = 16'd3;
        iDeassert_time = 16'd5;
`ifdef DEBOUNCE_GLITCH_CNT_EN
        iGlitch_clr    = 1'b0;
`endif
        repeat (3) @(negedge iCLK);
        checkOutput("rst_out", 32'(oOut), 32'(RST_VAL));
        checkOutput("rst_chg", 32'(oChg), 32'd0);
        checkOutput("rst_any", 32'(oAny_chg), 32'd0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
        checkOutput("rst_glitch", oGlitch_cnt, 32'd0);
`endif
        iRst_n = 1'b1;
        mon_en = 1'b1;
        repeat (4) @(negedge iCLK);

        // Channel 0: rise after 3 ticks, fall after 5 ticks.
        applyStimulus(4'b1001, entry);
        expectToggle(nthTick(entry, 3), 4'b0001);
        waitDrain(100);
        applyStimulus(4'b1000, entry);
        expectToggle(nthTick(entry, 5), 4'b0001);
        waitDrain(100);

        // Channel 1: short pulses never qualify, each counts as a glitch.
        iAssert_time = 16'd4;
        for (int r = 0; r < 300; r++) begin
            iIn[1] = 1'b1;
            repeat (8) @(negedge iCLK);
            iIn[1] = 1'b0;
            repeat (6) @(negedge iCLK);
`ifdef DEBOUNCE_GLITCH_CNT_EN
            if (r == 0) checkOutput("glitch_one", 32'(oGlitch_cnt[15:8]), 32'd1);
`endif
        end
`ifdef DEBOUNCE_GLITCH_CNT_EN
        checkOutput("glitch_sat", 32'(oGlitch_cnt[15:8]), 32'd255);
        iGlitch_clr = 1'b1;
        @(negedge iCLK);
        iGlitch_clr = 1'b0;
        @(negedge iCLK);
        checkOutput("glitch_clr", 32'(oGlitch_cnt[15:8]), 32'd0);
        // Clear in the same cycle as an abort: clear wins.
        iIn[1] = 1'b1;
        repeat (8) @(negedge iCLK);
        iIn[1] = 1'b0;
        repeat (2) @(negedge iCLK);
        iGlitch_clr = 1'b1;
        @(negedge iCLK);
        iGlitch_clr = 1'b0;
        repeat (4) @(negedge iCLK);
        checkOutput("glitch_clr_wins", 32'(oGlitch_cnt[15:8]), 32'd0);
`endif

        // Channel 1: abort coinciding with the qualifying tick must not toggle.
        iAssert_time = 16'd2;
        applyStimulus(4'b1010, entry);
        tgt = nthTick(entry, 2);
        waitEdge(tgt - 3);
        iIn[1] = 1'b0;
        repeat (8) @(negedge iCLK);
`ifdef DEBOUNCE_GLITCH_CNT_EN
        checkOutput("abort_tick_glitch", 32'(oGlitch_cnt[15:8]), 32'd1);
`endif

        // Channel 2: zero thresholds follow the input 3 edges later, ticks or not.
        iAssert_time   = 16'd0;
        iDeassert_time = 16'd0;
        for (int k = 0; k < 5; k++) begin
            tick_en = (k < 2);
            applyStimulus(iIn ^ 4'b0100, entry);
            expectToggle(entry, 4'b0100);
            repeat (5) @(negedge iCLK);
        end
        tick_en = 1'b1;
        waitDrain(50);

        // Channel 3: reset at count 2 of a de-assert qualification.
        iAssert_time   = 16'd3;
        iDeassert_time = 16'd5;
        applyStimulus(4'b0100, entry);
        waitEdge(nthTick(entry, 2));
        #2;
        iRst_n = 1'b0;
        mon_en = 1'b0;
        sb.delete();
        #1;
        checkOutput("async_rst_out", 32'(oOut), 32'(RST_VAL));
        checkOutput("async_rst_chg", 32'(oChg), 32'd0);
        repeat (3) @(negedge iCLK);
        exp_level = RST_VAL;
        iRst_n    = 1'b1;
        mon_en    = 1'b1;
        entry     = cyc + 3;
        expectToggle(nthTick(entry, 3), 4'b0100);
        expectToggle(nthTick(entry, 5), 4'b1000);
        waitDrain(200);

        // All channels rise on the same edge.
        iDeassert_time = 16'd0;
        applyStimulus(4'b0000, entry);
        expectToggle(entry, 4'b0100);
        waitDrain(50);
        iAssert_time = 16'd2;
        applyStimulus(4'b1111, entry);
        expectToggle(nthTick(entry, 2), 4'b1111);
        waitDrain(100);

        // Lowering the threshold below the running count ends on the next tick.
        iDeassert_time = 16'd10;
        applyStimulus(4'b1110, entry);
        waitEdge(nthTick(entry, 6));
        iDeassert_time = 16'd3;
        expectToggle(nthTick(entry, 7), 4'b0001);
        waitDrain(100);

        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, %0d tests run", tests);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/debounce_array.md
# debounce_array

Multi-channel debounce for presence, alert and button inputs on the CPLD. It synchronises each input and qualifies each level change against a tick-based timebase. Assert and de-assert hold times are set separately. Each channel reports its debounced level and a one-cycle change pulse. This block replaces single-channel, single-delay debounce instances wherever several related signals share one timebase.

## Interface
- CH, 8: number of channels, 1..32
- CNT_W, 16: width of the hold-time counters and threshold inputs
- RST_VAL, {CH{1'b0}}: per-channel debounced level loaded at reset
- iCLK  in  1  system clock
- iRst_n  in  1  asynchronous, active-low reset
- iTick  in  1  timebase strobe, one iCLK cycle wide, from a shared prescaler
- iAssert_time  in  CNT_W  ticks an input must hold 1 before its output rises
- iDeassert_time  in  CNT_W  ticks an input must hold 0 before its output falls
- iIn  in  CH  raw asynchronous inputs
- oOut  out  CH  debounced levels
- oChg  out  CH  one-cycle pulse per channel when its oOut toggles
- oAny_chg  out  1  registered OR of all oChg bits; asserts on the same cycle as the oChg bit
- oGlitch_cnt  out  8*CH  per-channel glitch counters, channel n at [8n+7:8n]; present only with the macro defined
- iGlitch_clr  in  1  synchronous clear of all glitch counters; present only with the macro defined

## Operation
- Each iIn bit passes through a 2-flop synchroniser; s[n] is the synchronised bit.
- Per-channel FSM states:
  - IDLE: s == oOut, counter held at 0.
  - QUAL: s != oOut, counter advances on iTick.
- Threshold selection per channel: thr = iAssert_time when oOut = 0, else iDeassert_time.
- IDLE with s != oOut:
  - thr == 0: toggle oOut immediately, pulse oChg, stay in IDLE.
  - thr != 0: go to QUAL with counter = 0. An iTick on this entry cycle is ignored.
- QUAL with s == oOut: an abort. Go to IDLE, clear the counter, oOut unchanged, and record a glitch event.
- QUAL with s != oOut and iTick:
  - counter >= thr-1: toggle oOut, pulse oChg, go to IDLE, clear the counter.
  - otherwise: counter + 1.
- A threshold change mid-qualification takes effect on the next compare. The >= compare guarantees termination when thr drops below the current count.
- Counter width is CNT_W and it never exceeds thr-1, so it cannot wrap.
- Channels are fully independent. Any number may toggle on the same cycle.

## Timing
- Reset values:
  - oOut = RST_VAL
  - oChg = 0, oAny_chg = 0
  - both synchroniser stages = RST_VAL
  - all FSMs in IDLE, all counters 0, all glitch counters 0
- Input-to-s latency: 2 iCLK edges.
- thr == 0: oOut toggles 1 iCLK edge after s changes, 3 edges after iIn.
- thr == N > 0: oOut toggles on the edge that samples the N-th iTick after QUAL entry.
- oChg is high for exactly the cycle in which the new oOut value first appears. oAny_chg follows the same timing.
- An abort and a tick on the same cycle: the abort wins and no count is taken.
- Reset asserted mid-qualification discards the count and returns every output to its reset value asynchronously.

## Configuration
- DEBOUNCE_GLITCH_CNT_EN defined:
  - Each channel keeps an 8-bit saturating counter (holds at 255), incremented on every QUAL abort.
  - iGlitch_clr zeroes all counters. If clear and increment occur on the same cycle, clear wins.
  - oGlitch_cnt and iGlitch_clr ports exist.
- DEBOUNCE_GLITCH_CNT_EN undefined: the counters and both ports are removed. Debounce behaviour is identical.

## Structure
- debounce_pkg holds:
  - the channel state enum (DB_IDLE, DB_QUAL)
  - GLITCH_W = 8
  - GLITCH_MAX = 8'hFF
- Sub-module debounce_ch covers one channel: synchroniser, FSM, counter and optional glitch counter.
- debounce_array instantiates CH copies in a generate loop, ORs the oChg bits and flattens the glitch buses.

## Test plan
- CH=4, assert=3, deassert=5, iTick every 4 cycles; raise iIn[0] and hold. oOut[0] rises on the 3rd tick after QUAL entry with a single oChg[0] pulse; then drop iIn[0]. oOut[0] falls on the 5th tick after QUAL entry.
- assert=4; pulse iIn[1] high for 2 ticks, then low. oOut[1] stays 0, no oChg, glitch_cnt[1] = 1. Repeat 300 times: glitch_cnt[1] = 255. Pulse iGlitch_clr: 0.
- assert=0, deassert=0; toggle iIn[2]. oOut[2] follows 3 edges later with oChg[2] on every toggle, regardless of iTick.
- Assert iRst_n low during QUAL on channel 3 at count 2, RST_VAL=4'b1000. oOut = 4'b1000 immediately. After release, the same input must see a full qualification.
- Raise all 4 inputs simultaneously with assert=2. All oOut bits rise on the same edge; oChg = 4'hF and oAny_chg = 1 for one cycle.
- QUAL at count 6, lower iDeassert_time from 10 to 3 while oOut=1. oOut falls on the next iTick.
